// File: rtl/cnt_chk_pkg.sv
// Shared types and helpers for the counter-stream sequence checker.
// Holds the FSM state encoding, default widths and the saturating increment.
package cnt_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_e;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_RELOCK_N  = 4;
    localparam int DEF_ERR_CNT_W = 16;

    // Callers zero-extend into 64 bits and truncate the result back to their width.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
        return (val >= max_val) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/cnt_stream_checker_if.sv
// Stream bundle between the gated counter source (master) and the checker (slave).
// The slave modport carries the checker's status outputs back to the consumer.
interface cnt_stream_checker_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 16
);
    logic                 en;
    logic [WIDTH-1:0]     data;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic [WIDTH-1:0]     bad_data;

    modport master (
        output en, data,
        input  locked, err_pulse, err_count, bad_data
    );

    modport slave (
        input  en, data,
        output locked, err_pulse, err_count, bad_data
    );
endinterface

// File: rtl/cnt_chk_sat_counter.sv
// Generic W-bit up-counter that sticks at all-ones; advances by one on inc_i.
module cnt_chk_sat_counter
    import cnt_chk_pkg::*;
#(
    parameter int W = DEF_ERR_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = W'(sat_inc(64'(count_q), 64'(MAX_VAL)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/cnt_stream_checker.sv
// Consumer-side checker for a gated incrementing counter stream: locks, then flags skips/repeats.
// Define CNT_CHK_ZERO_CHECK_EN to also flag non-zero data while en is low.
module cnt_stream_checker
    import cnt_chk_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RELOCK_N  = DEF_RELOCK_N,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    cnt_stream_checker_if.slave  stream
);
    localparam int GOOD_W = $clog2(RELOCK_N + 1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    exp_q, exp_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic                locked_q;
    logic                err_pulse_q;
    logic [WIDTH-1:0]    bad_data_q, bad_data_d;
    logic                err;
    logic                data_match;
    logic [ERR_CNT_W-1:0] err_count;

    assign data_match = stream.en && (stream.data == exp_q);

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can infer a latch.
        state_d    = state_q;
        exp_d      = exp_q;
        good_d     = good_q;
        err        = 1'b0;

        // Expected value tracks the source whenever it is valid, regardless of state.
        if (stream.en) begin
            exp_d = stream.data + WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (stream.en) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end
            ACQ: begin
                if (!stream.en) begin
                    state_d = IDLE;
                end else if (data_match) begin
                    good_d = good_q + GOOD_W'(1);
                    if (good_d == GOOD_W'(RELOCK_N)) begin
                        state_d = TRACK;
                    end
                end else begin
                    good_d = '0;
                end
            end
            TRACK: begin
                if (!stream.en) begin
                    state_d = IDLE;
                end else if (!data_match) begin
                    err     = 1'b1;
                    good_d  = '0;
                    state_d = ACQ;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase

`ifdef CNT_CHK_ZERO_CHECK_EN
        // A gated-off source must drive zero; anything else is corruption on the bus.
        if (!stream.en && (stream.data != '0)) begin
            err = 1'b1;
        end
`endif
    end

    always_comb begin
        bad_data_d = bad_data_q;
        if (err) begin
            bad_data_d = stream.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            good_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            bad_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            exp_q       <= exp_d;
            good_q      <= good_d;
            locked_q    <= (state_d == TRACK);
            err_pulse_q <= err;
            bad_data_q  <= bad_data_d;
        end
    end

    cnt_chk_sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (err),
        .count_o (err_count)
    );

    assign stream.locked    = locked_q;
    assign stream.err_pulse = err_pulse_q;
    assign stream.err_count = err_count;
    assign stream.bad_data  = bad_data_q;
endmodule

// File: tb/tb_cnt_stream_checker.sv
// Scoreboard bench for cnt_stream_checker: a behavioural reference predicts each cycle's outputs.
// A second instance with a 2-bit error counter exercises saturation on the same stimulus.
module tb_cnt_stream_checker;

`ifdef CNT_CHK_ZERO_CHECK_EN
    localparam bit ZERO_CHK = 1'b1;
`else
    localparam bit ZERO_CHK = 1'b0;
`endif
    localparam int RELOCK_N = 4;

    typedef struct {
        logic        locked;
        logic        pulse;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic [7:0]  bad;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_cmp    = 0;
    int n_err    = 0;
    int n_pulse2 = 0;

    exp_t sb_q[$];

    // Reference model state
    bit          m_seen;
    bit          m_lock;
    int          m_run;
    logic [7:0]  m_exp;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;
    logic [7:0]  m_bad;
    logic        m_pulse;

    cnt_stream_checker_if #(.WIDTH(8), .ERR_CNT_W(16)) sif1 ();
    cnt_stream_checker_if #(.WIDTH(8), .ERR_CNT_W(2))  sif2 ();

    cnt_stream_checker #(.WIDTH(8), .RELOCK_N(RELOCK_N), .ERR_CNT_W(16)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .stream (sif1.slave)
    );

    cnt_stream_checker #(.WIDTH(8), .RELOCK_N(RELOCK_N), .ERR_CNT_W(2)) dut2 (
        .clk    (clk),
        .reset  (reset),
        .stream (sif2.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_seen  = 1'b0;
        m_lock  = 1'b0;
        m_run   = 0;
        m_exp   = 8'd0;
        m_cnt   = 16'd0;
        m_cnt2  = 2'd0;
        m_bad   = 8'd0;
        m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [7:0] d);
        bit e;
        e = 1'b0;
        if (!en) begin
            if (ZERO_CHK && d != 8'd0) e = 1'b1;
            m_seen = 1'b0;
            m_lock = 1'b0;
        end else begin
            if (!m_seen) begin
                m_seen = 1'b1;
                m_run  = 0;
            end else if (d == m_exp) begin
                if (!m_lock) begin
                    m_run++;
                    if (m_run == RELOCK_N) m_lock = 1'b1;
                end
            end else begin
                if (m_lock) e = 1'b1;
                m_lock = 1'b0;
                m_run  = 0;
            end
            m_exp = d + 8'd1;
        end
        m_pulse = e;
        if (e) begin
            m_bad = d;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt2 != 2'd3)    m_cnt2 = m_cnt2 + 2'd1;
        end
    endtask

    task automatic cycle(input logic en, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        sif1.en   = en;
        sif1.data = d;
        sif2.en   = en;
        sif2.data = d;
        model_step(en, d);
        e.locked = m_lock;
        e.pulse  = m_pulse;
        e.cnt    = m_cnt;
        e.cnt2   = m_cnt2;
        e.bad    = m_bad;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("locked",     32'(sif1.locked),    32'(e.locked));
        check("err_pulse",  32'(sif1.err_pulse), 32'(e.pulse));
        check("err_count",  32'(sif1.err_count), 32'(e.cnt));
        check("bad_data",   32'(sif1.bad_data),  32'(e.bad));
        check("err_pulse2", 32'(sif2.err_pulse), 32'(e.pulse));
        check("err_count2", 32'(sif2.err_count), 32'(e.cnt2));
        if (sif2.err_pulse) n_pulse2++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},  32'(sif1.locked),    32'd0);
        check({tag, "_pulse"},   32'(sif1.err_pulse), 32'd0);
        check({tag, "_count"},   32'(sif1.err_count), 32'd0);
        check({tag, "_bad"},     32'(sif1.bad_data),  32'd0);
        check({tag, "_count2"},  32'(sif2.err_count), 32'd0);
        check({tag, "_pulse2"},  32'(sif2.err_pulse), 32'd0);
    endtask

    initial begin
        sif1.en = 1'b0; sif1.data = 8'd0;
        sif2.en = 1'b0; sif2.data = 8'd0;
        model_reset();

        // Reset held, then released idle
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 8'd0);
        check_all_zero("post_reset");

        // Acquire: lock on the edge sampling 14
        for (int v = 10; v <= 13; v++) cycle(1'b1, 8'(v));
        check("not_locked_13", 32'(sif1.locked), 32'd0);
        cycle(1'b1, 8'd14);
        check("locked_at_14", 32'(sif1.locked), 32'd1);
        check("no_err_acq", 32'(sif1.err_count), 32'd0);

        // Skip detection while tracking
        for (int v = 15; v <= 21; v++) cycle(1'b1, 8'(v));
        cycle(1'b1, 8'd23);
        check("skip_pulse",  32'(sif1.err_pulse), 32'd1);
        check("skip_count",  32'(sif1.err_count), 32'd1);
        check("skip_bad",    32'(sif1.bad_data),  32'd23);
        check("skip_unlock", 32'(sif1.locked),    32'd0);
        for (int v = 24; v <= 27; v++) cycle(1'b1, 8'(v));
        check("relock_27", 32'(sif1.locked), 32'd1);

        // One-cycle gap is a fresh stream, not an error
        cycle(1'b0, 8'd0);
        check("gap_unlock", 32'(sif1.locked),    32'd0);
        check("gap_no_err", 32'(sif1.err_count), 32'd1);

        // Wrap from 255 to 0 while locked
        for (int v = 250; v <= 254; v++) cycle(1'b1, 8'(v));
        check("locked_254", 32'(sif1.locked), 32'd1);
        cycle(1'b1, 8'd255);
        cycle(1'b1, 8'd0);
        cycle(1'b1, 8'd1);
        check("wrap_locked", 32'(sif1.locked),    32'd1);
        check("wrap_no_err", 32'(sif1.err_count), 32'd1);

        // Non-zero data while gated off
        cycle(1'b0, 8'd5);
        check("zero_chk_pulse", 32'(sif1.err_pulse), 32'(ZERO_CHK));
        check("zero_chk_bad",   32'(sif1.bad_data),  ZERO_CHK ? 32'd5 : 32'd23);

        // Five TRACK mismatches, each after a relock; 2-bit counter must stick at 3
        n_pulse2 = 0;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 5; j++) cycle(1'b1, 8'(40 + 30 * k + j));
            check("sat_locked", 32'(sif1.locked), 32'd1);
            cycle(1'b1, 8'(40 + 30 * k + 13));
        end
        check("sat_pulses",  32'(n_pulse2),        32'd5);
        check("sat_count2",  32'(sif2.err_count),  32'd3);
        check("sat_count16", 32'(sif1.err_count),  32'd6 + 32'(ZERO_CHK));
        check("sat_bad2",    32'(sif2.bad_data),   32'd173);

        // Reset asserted mid-ACQ clears everything without a clock edge
        cycle(1'b1, 8'd100);
        cycle(1'b1, 8'd101);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        sif1.en = 1'b0; sif2.en = 1'b0;
        sif1.data = 8'd0; sif2.data = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 8'd0);
        for (int v = 110; v <= 113; v++) cycle(1'b1, 8'(v));
        check("reacq_not_yet", 32'(sif1.locked), 32'd0);
        cycle(1'b1, 8'd114);
        check("reacq_locked", 32'(sif1.locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
